// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone B4 pipelined arbiter in front of one slave port.
// Round-robin grant held for a whole master cycle, outstanding-transfer counting
// with saturation at 15, and a timeout abort for hung cycles.
module wb_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_adr_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
    input  logic [DATA_WIDTH-1:0]     m0_dat_i,
    output logic [DATA_WIDTH-1:0]     m0_dat_o,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    output logic                      m0_stall_o,

    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_adr_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    input  logic [DATA_WIDTH-1:0]     m1_dat_i,
    output logic [DATA_WIDTH-1:0]     m1_dat_o,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic                      m1_stall_o,

    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDR_WIDTH-1:0]     s_adr_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    input  logic [DATA_WIDTH-1:0]     s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_stall_i,

    output logic [1:0]                owner_o,
    output logic                      timeout_o
);

    localparam int unsigned SEL_W   = DATA_WIDTH / 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_ABORT = 2'd2
    } state_e;

    typedef struct packed {
        logic                  cyc;
        logic                  stb;
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [SEL_W-1:0]      sel;
        logic [DATA_WIDTH-1:0] dat;
    } wb_req_t;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    wb_req_t          m0_req, m1_req, own_req;
    logic             sat, resp, to_fire, accept, dec, grant;

    // Bundle each master's request for a single owner mux.
    assign m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                      adr: m0_adr_i, sel: m0_sel_i, dat: m0_dat_i};
    assign m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                      adr: m1_adr_i, sel: m1_sel_i, dat: m1_dat_i};

    // Read data is broadcast; only ack/err are steered to the owner.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Owner request selection and per-cycle status flags.
    always_comb begin
        own_req = owner_q ? m1_req : m0_req;
        sat     = (out_cnt_q == CNT_MAX);
        resp    = s_ack_i | s_err_i;
        to_fire = (TIMEOUT > 0) && (state_q == S_OWN) && own_req.cyc &&
                  (out_cnt_q != '0) && !resp && (to_cnt_q == TO_W'(TO_LAST));
    end

    // Next-state, counter updates and all bus outputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        out_cnt_d  = out_cnt_q;
        to_cnt_d   = to_cnt_q;
        grant      = 1'b0;
        accept     = 1'b0;
        dec        = 1'b0;

        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_sel_o    = '0;
        s_dat_o    = '0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        owner_o    = 2'b00;
        timeout_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    // On a tie the master that did not win last time goes first.
                    grant     = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
                    owner_d   = grant;
                    last_d    = grant;
                    out_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = S_OWN;
                end
            end

            S_OWN: begin
                s_cyc_o = own_req.cyc & ~to_fire;
                s_stb_o = own_req.stb & ~sat & ~to_fire;
                s_we_o  = own_req.we;
                s_adr_o = own_req.adr;
                s_sel_o = own_req.sel;
                s_dat_o = own_req.dat;
                owner_o = owner_q ? 2'b10 : 2'b01;

                if (owner_q) begin
                    m1_stall_o = s_stall_i | sat;
                    m1_ack_o   = s_ack_i;
                    m1_err_o   = s_err_i | to_fire;
                end else begin
                    m0_stall_o = s_stall_i | sat;
                    m0_ack_o   = s_ack_i;
                    m0_err_o   = s_err_i | to_fire;
                end

                accept = s_stb_o & ~s_stall_i;
                // A response with nothing outstanding must not underflow the count.
                dec    = resp && (out_cnt_q != '0);
                case ({accept, dec})
                    2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
                    2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
                    default: out_cnt_d = out_cnt_q;
                endcase

                if ((TIMEOUT == 0) || resp || (out_cnt_q == '0)) begin
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end

                if (!own_req.cyc) begin
                    // Master ended its cycle: any outstanding transfers are abandoned.
                    state_d   = S_IDLE;
                    out_cnt_d = '0;
                    to_cnt_d  = '0;
                end else if (to_fire) begin
                    timeout_o = 1'b1;
                    state_d   = S_ABORT;
                    out_cnt_d = '0;
                    to_cnt_d  = '0;
                end
            end

            S_ABORT: begin
                state_d   = S_IDLE;
                out_cnt_d = '0;
                to_cnt_d  = '0;
            end

            default: begin
                state_d   = S_IDLE;
                out_cnt_d = '0;
                to_cnt_d  = '0;
            end
        endcase
    end

    // State and counter registers; last resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            out_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            out_cnt_q <= out_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: one instance with the default timeout and
// one with TIMEOUT=8, both driven by the same master/slave stimulus.
module tb_wb_arbiter_2m;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [SW-1:0] m0_sel, m1_sel;
    logic [DW-1:0] m0_wdat, m1_wdat;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_err, s_stall;

    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
    logic          s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [AW-1:0] s_adr_o;
    logic [SW-1:0] s_sel_o;
    logic [1:0]    owner_o;

    logic [DW-1:0] t_m0_dat_o, t_m1_dat_o, t_s_dat_o;
    logic          t_m0_ack_o, t_m0_err_o, t_m0_stall_o, t_m1_ack_o, t_m1_err_o, t_m1_stall_o;
    logic          t_s_cyc_o, t_s_stb_o, t_s_we_o, t_timeout_o;
    logic [AW-1:0] t_s_adr_o;
    logic [SW-1:0] t_s_sel_o;
    logic [1:0]    t_owner_o;

    int n_checks = 0;
    int n_errors = 0;
    int accepted;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(1024)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .s_err_i(s_err), .s_stall_i(s_stall), .owner_o(owner_o), .timeout_o(timeout_o)
    );

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) u_dut_to (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_dat_o(t_m0_dat_o), .m0_ack_o(t_m0_ack_o),
        .m0_err_o(t_m0_err_o), .m0_stall_o(t_m0_stall_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_dat_o(t_m1_dat_o), .m1_ack_o(t_m1_ack_o),
        .m1_err_o(t_m1_err_o), .m1_stall_o(t_m1_stall_o),
        .s_cyc_o(t_s_cyc_o), .s_stb_o(t_s_stb_o), .s_we_o(t_s_we_o), .s_adr_o(t_s_adr_o),
        .s_sel_o(t_s_sel_o), .s_dat_o(t_s_dat_o), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .s_err_i(s_err), .s_stall_i(s_stall), .owner_o(t_owner_o), .timeout_o(t_timeout_o)
    );

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '1; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '1; m1_wdat = '0;
        s_rdat = 32'h1234_5678; s_ack = 0; s_err = 0; s_stall = 0;
        tick();
        #1;
        chk("rst_owner",   64'(owner_o), 64'h0);
        chk("rst_s_cyc",   64'(s_cyc_o), 64'h0);
        chk("rst_m0_stall", 64'(m0_stall_o), 64'h1);
        chk("rst_m1_stall", 64'(m1_stall_o), 64'h1);
        chk("rst_timeout", 64'(timeout_o), 64'h0);
        chk("rst_m0_dat",  64'(m0_dat_o), 64'h1234_5678);

        // Single read by m0, slave acks three cycles after acceptance.
        tick();
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_4000;
        #1;
        chk("rd_c0_stall", 64'(m0_stall_o), 64'h1);
        chk("rd_c0_s_cyc", 64'(s_cyc_o), 64'h0);
        tick();
        #1;
        chk("rd_c1_owner", 64'(owner_o), 64'h1);
        chk("rd_c1_s_cyc", 64'(s_cyc_o), 64'h1);
        chk("rd_c1_s_stb", 64'(s_stb_o), 64'h1);
        chk("rd_c1_s_adr", 64'(s_adr_o), 64'h4000);
        chk("rd_c1_stall", 64'(m0_stall_o), 64'h0);
        chk("rd_c1_m1_stall", 64'(m1_stall_o), 64'h1);
        tick();
        m0_stb = 0;
        tick();
        tick();
        s_ack = 1; s_rdat = 32'hA5A5_0001;
        #1;
        chk("rd_ack", 64'(m0_ack_o), 64'h1);
        chk("rd_dat", 64'(m0_dat_o), 64'hA5A5_0001);
        chk("rd_m1_ack", 64'(m1_ack_o), 64'h0);
        tick();
        s_ack = 0; m0_cyc = 0;
        #1;
        chk("rd_rel_s_cyc", 64'(s_cyc_o), 64'h0);
        chk("rd_rel_owner", 64'(owner_o), 64'h1);
        tick();
        #1;
        chk("rd_idle_owner", 64'(owner_o), 64'h0);

        // Contention right after reset: m0, then m1, then m0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_cyc = 1; m1_cyc = 1;
        tick();
        s_ack = 1;
        #1;
        chk("ct_first_owner", 64'(owner_o), 64'h1);
        chk("ct_m0_ack", 64'(m0_ack_o), 64'h1);
        chk("ct_m1_no_ack", 64'(m1_ack_o), 64'h0);
        tick();
        s_ack = 0; m0_cyc = 0;
        #1;
        chk("ct_rel_s_cyc", 64'(s_cyc_o), 64'h0);
        tick();
        m0_cyc = 1;
        #1;
        chk("ct_idle_owner", 64'(owner_o), 64'h0);
        tick();
        m1_cyc = 0;
        #1;
        chk("ct_second_owner", 64'(owner_o), 64'h2);
        tick();
        m1_cyc = 1;
        tick();
        #1;
        chk("ct_third_owner", 64'(owner_o), 64'h1);
        m0_cyc = 0; m1_cyc = 0;
        tick();
        tick();

        // Saturation: 20 strobes with no ack, exactly 15 accepted.
        m0_cyc = 1;
        tick();
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            m0_stb = 1;
            #1;
            chk($sformatf("sat_stb%0d", i), 64'(s_stb_o), (i < 15) ? 64'h1 : 64'h0);
            chk($sformatf("sat_stall%0d", i), 64'(m0_stall_o), (i >= 15) ? 64'h1 : 64'h0);
            if (s_stb_o && !s_stall) accepted++;
            tick();
        end
        chk("sat_accepted", 64'(accepted), 64'd15);
        m0_stb = 0;
        for (int i = 0; i < 15; i++) begin
            s_ack = 1;
            #1;
            chk($sformatf("sat_ack%0d", i), 64'(m0_ack_o), 64'h1);
            tick();
        end
        s_ack = 0;
        for (int i = 0; i < 16; i++) begin
            m0_stb = 1;
            #1;
            chk($sformatf("sat_refill%0d", i), 64'(m0_stall_o), (i == 15) ? 64'h1 : 64'h0);
            tick();
        end
        m0_stb = 0; m0_cyc = 0;
        tick();
        tick();

        // Timeout on the TIMEOUT=8 instance with m1 owning.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m1_cyc = 1; m1_stb = 1;
        tick();
        #1;
        chk("to_owner", 64'(t_owner_o), 64'h2);
        chk("to_s_stb", 64'(t_s_stb_o), 64'h1);
        tick();
        m1_stb = 0;
        for (int c = 2; c <= 8; c++) begin
            #1;
            chk($sformatf("to_wait%0d", c), 64'({t_timeout_o, t_s_cyc_o}), 64'h1);
            tick();
        end
        #1;
        chk("to_fire_timeout", 64'(t_timeout_o), 64'h1);
        chk("to_fire_m1_err", 64'(t_m1_err_o), 64'h1);
        chk("to_fire_m0_err", 64'(t_m0_err_o), 64'h0);
        chk("to_fire_s_cyc", 64'(t_s_cyc_o), 64'h0);
        tick();
        s_ack = 1;
        #1;
        chk("to_abort_ack", 64'(t_m1_ack_o), 64'h0);
        chk("to_abort_s_cyc", 64'(t_s_cyc_o), 64'h0);
        chk("to_abort_stall", 64'(t_m1_stall_o), 64'h1);
        chk("to_abort_pulse", 64'(t_timeout_o), 64'h0);
        chk("to_abort_owner", 64'(t_owner_o), 64'h0);
        tick();
        s_ack = 0;
        #1;
        chk("to_idle_owner", 64'(t_owner_o), 64'h0);
        tick();
        #1;
        chk("to_regrant", 64'(t_owner_o), 64'h2);
        m1_cyc = 0;
        tick();
        tick();

        // Master abort: m0 drops cyc with two outstanding; m1 takes over.
        m0_cyc = 1; m0_stb = 1;
        tick();
        tick();
        tick();
        m0_stb = 0; m1_cyc = 1;
        tick();
        m0_cyc = 0;
        #1;
        chk("ab_s_cyc", 64'(s_cyc_o), 64'h0);
        tick();
        s_ack = 1;
        #1;
        chk("ab_late_ack", 64'({m1_ack_o, m0_ack_o}), 64'h0);
        chk("ab_idle_owner", 64'(owner_o), 64'h0);
        tick();
        s_ack = 0;
        #1;
        chk("ab_m1_owner", 64'(owner_o), 64'h2);

        // Async reset mid-write while m1 owns; m0 then wins the tie.
        m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0010;
        #1;
        chk("ar_pre_s_we", 64'(s_we_o), 64'h1);
        chk("ar_pre_s_cyc", 64'(s_cyc_o), 64'h1);
        rst = 1'b1;
        #1;
        chk("ar_s_cyc", 64'(s_cyc_o), 64'h0);
        chk("ar_s_stb", 64'(s_stb_o), 64'h0);
        chk("ar_owner", 64'(owner_o), 64'h0);
        chk("ar_m1_stall", 64'(m1_stall_o), 64'h1);
        rst = 1'b0;
        m0_cyc = 1;
        tick();
        #1;
        chk("ar_tie_owner", 64'(owner_o), 64'h1);

        m0_cyc = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone (pipelined, B4) arbiter that shares the single slave port of the register crossbar between two hosts. Typical hosts are a host-bus bridge on m0 and the I2C-to-WB bridge on m1. Grants are round-robin, held for a whole master cycle (CYC high). The arbiter counts outstanding transfers and aborts hung cycles with a timeout error. It sits directly in front of the crossbar's `wb` slave interface, in the same clock domain.

## Interface

Parameters:
- ADDR_WIDTH, 32: address width on all ports.
- DATA_WIDTH, 32: data width; SEL width is DATA_WIDTH/8.
- TIMEOUT, 1024: cycles without ACK/ERR while transfers are outstanding before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  reset, asynchronous, active-high.
- mN_cyc_i, mN_stb_i, mN_we_i  in  1  master N cycle/strobe/write (N = 0, 1).
- mN_adr_i  in  ADDR_WIDTH  master N address.
- mN_sel_i  in  DATA_WIDTH/8  master N byte select.
- mN_dat_i  in  DATA_WIDTH  master N write data.
- mN_dat_o  out  DATA_WIDTH  read data, = s_dat_i to both masters.
- mN_ack_o, mN_err_o  out  1  acknowledge / error, only to the owner.
- mN_stall_o  out  1  stall.
- s_cyc_o, s_stb_o, s_we_o  out  1  to crossbar.
- s_adr_o  out  ADDR_WIDTH  to crossbar.
- s_sel_o  out  DATA_WIDTH/8  to crossbar.
- s_dat_o  out  DATA_WIDTH  to crossbar.
- s_dat_i  in  DATA_WIDTH  from crossbar.
- s_ack_i, s_err_i, s_stall_i  in  1  from crossbar.
- owner_o  out  2  one-hot current owner; 00 when no master owns the bus.
- timeout_o  out  1  one-cycle pulse on abort.

## Operation

- FSM states: IDLE, OWN, ABORT. Registers:
  - owner (1 bit)
  - last (1 bit, last granted master)
  - out_cnt (4 bits, outstanding transfers)
  - to_cnt (timeout counter, width clog2(TIMEOUT+1))
- IDLE:
  - all s_* outputs low; both mN_stall_o = 1; ack/err low.
  - If exactly one mN_cyc_i is high, grant that master: owner <= N, -> OWN.
  - If both are high, grant the master != last.
  - On every grant, last <= granted master; out_cnt, to_cnt <= 0.
- OWN:
  - s_cyc_o = owner's cyc.
  - s_stb_o = owner's stb & (out_cnt != 15).
  - s_we_o, s_adr_o, s_sel_o, s_dat_o = owner's signals.
  - Owner mN_stall_o = s_stall_i | (out_cnt == 15); non-owner stall = 1.
  - Owner ack_o = s_ack_i; owner err_o = s_err_i; non-owner ack/err = 0.
  - out_cnt += accept (s_stb_o & ~s_stall_i); out_cnt -= (s_ack_i | s_err_i). Simultaneous accept and ack leaves the count unchanged.
  - Owner drops cyc: -> IDLE and out_cnt <= 0 (WB abort semantics). Late ACK/ERR arriving in IDLE is ignored and not forwarded.
- Timeout (TIMEOUT > 0):
  - to_cnt increments each OWN cycle with out_cnt != 0 and no s_ack_i/s_err_i.
  - to_cnt clears on s_ack_i/s_err_i or when out_cnt == 0.
  - When to_cnt reaches TIMEOUT-1 and increments: owner err_o = 1 and timeout_o = 1 for that cycle, s_cyc_o forced 0 in the same cycle, -> ABORT.
- ABORT:
  - s_cyc_o = 0 and both stalls = 1 for exactly one cycle, then -> IDLE.
  - out_cnt <= 0; late acks are ignored.
  - A new grant needs the master to present cyc again in IDLE; a held cyc is re-granted by the normal round-robin rule.
- out_cnt saturation: at 15 the owner is stalled and no STB is forwarded. The count never wraps.

## Timing

- Reset (rst_i high, async):
  - state IDLE, owner_o = 00, last = 1 (m0 wins first tie), counters 0.
  - All s_* outputs = 0, mN_ack_o = mN_err_o = timeout_o = 0, mN_stall_o = 1, mN_dat_o follows s_dat_i.
  - Reset asserted mid-transfer drops s_cyc_o immediately (combinationally, from state).
- Grant latency: one cycle.
  - mN_cyc_i rises in cycle 0 -> owner_o and s_cyc_o high in cycle 1.
  - Master sees stall = 1 in cycle 0.
- Data path is combinational in OWN:
  - request outputs follow the owner inputs with zero latency;
  - ACK/ERR/DAT reach the master in the same cycle as the crossbar returns them.
- Release: owner cyc low in cycle k -> IDLE in cycle k+1 (s_cyc_o low already in cycle k) -> next grant visible in cycle k+2.
- Back-to-back alternation: m0 and m1 both requesting continuously alternate owners per master cycle.

## Test plan

- Single read: m0 cyc/stb, adr=0x4000, crossbar acks after 3 cycles with dat=0xA5A5_0001 -> s_cyc_o in cycle 1, m0_ack_o high with m0_dat_o=0xA5A5_0001, owner_o 01 then 00.
- Contention: m0 and m1 raise cyc in the same cycle after reset -> m0 granted first. After m0 releases and both request again -> m1 granted, then m0. m1 never sees ack during m0 ownership.
- Saturation: slave stall=0, ack withheld, owner issues 20 strobes -> exactly 15 accepted, mN_stall_o=1 while out_cnt=15. After 15 acks out_cnt=0.
- Timeout: TIMEOUT=8, one accepted read, no ack -> after 8 stalled cycles owner err_o=1 and timeout_o=1 for 1 cycle, s_cyc_o=0. An ack injected one cycle later is not forwarded.
- Master abort: owner drops cyc with 2 outstanding -> IDLE next cycle, late s_ack_i not forwarded, the other master granted within 2 cycles.
- Async reset mid-write: rst_i pulsed between edges while owning -> s_cyc_o/s_stb_o low immediately, owner_o=00, m0 wins the next tie.
